// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: FSM fetch/PC handshake, instruction-memory req/ack, fetch results.
// No latency of its own; the slave modport (the fetch unit) holds imem_req until imem_ack.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 8
);
    logic               en_fetch_pulse;
    logic               en_pc_pulse;
    logic [1:0]         pc_ctrl;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic               en1;
    logic               busy;
    logic               fetch_err;

    modport master (
        output en_fetch_pulse, en_pc_pulse, pc_ctrl, pc_load_val, imem_ack, imem_rdata,
        input  imem_req, imem_addr, pc, ir, opcode, rd, rs, en1, busy, fetch_err
    );

    modport slave (
        input  en_fetch_pulse, en_pc_pulse, pc_ctrl, pc_load_val, imem_ack, imem_rdata,
        output imem_req, imem_addr, pc, ir, opcode, rd, rs, en1, busy, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, does one imem req/ack read per fetch pulse; IFU_TIMEOUT_EN adds an ack timeout.
// Latency: fetch pulse in cycle 0, ack in cycle k -> en1 in cycle k+1 (zero-wait memory gives cycle 2).
// Backpressure: holds imem_req/imem_addr until imem_ack; fetch pulses while busy are dropped.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("instr_fetch_unit: TIMEOUT must be at least 2");
        end
    endgenerate

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [INSTR_W-1:0] r_ir;
    logic               r_imem_req;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic               r_en1;
    logic               r_busy;
    logic               r_fetch_err;

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt;
`endif

    // PC updates are independent of the fetch state machine.
    always_comb begin
        w_pc_next = r_pc;
        if (bus.en_pc_pulse) begin
            case (bus.pc_ctrl)
                2'b01:   w_pc_next = r_pc + ADDR_W'(1);
                2'b10:   w_pc_next = bus.pc_load_val;
                2'b11:   w_pc_next = RESET_PC;
                default: w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_en1       <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Address comes from the pre-update PC even when a PC pulse coincides.
                    if (bus.en_fetch_pulse) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                        r_busy      <= 1'b1;
`ifdef IFU_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        r_state     <= S_DONE;
                        r_ir        <= bus.imem_rdata;
                        r_imem_req  <= 1'b0;
                        r_en1       <= 1'b1;
                        r_fetch_err <= 1'b0;
                    end
`ifdef IFU_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state     <= S_DONE;
                        r_ir        <= '0;
                        r_imem_req  <= 1'b0;
                        r_en1       <= 1'b1;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_en1       <= 1'b0;
                    r_fetch_err <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_imem_req  <= 1'b0;
                    r_en1       <= 1'b0;
                    r_fetch_err <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.ir        = r_ir;
    assign bus.opcode    = r_ir[7:4];
    assign bus.rd        = r_ir[3:2];
    assign bus.rs        = r_ir[1:0];
    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.en1       = r_en1;
    assign bus.busy      = r_busy;
    assign bus.fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with programmable ack delay,
// scoreboard of expected {ir, fetch_err} popped on every en1 pulse.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_en1   = 0;
    logic [7:0]  mem [256];
    logic [7:0]  m_pc = 8'h00;
    logic [8:0]  sb [$];
    int          mem_delay = 0;
    bit          force_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input cycle: drive fetch/PC strobes, push the expected fetch result, update the PC model.
    task automatic drive_cycle(input bit fetch, input bit pc_en, input logic [1:0] ctrl,
                               input logic [7:0] val, input bit push, input bit err);
        bus.en_fetch_pulse = fetch;
        bus.en_pc_pulse    = pc_en;
        bus.pc_ctrl        = ctrl;
        bus.pc_load_val    = val;
        if (push) sb.push_back(err ? 9'h001 : {mem[m_pc], 1'b0});
        if (pc_en) begin
            case (ctrl)
                2'b01:   m_pc = m_pc + 8'h01;
                2'b10:   m_pc = val;
                2'b11:   m_pc = 8'h00;
                default: m_pc = m_pc;
            endcase
        end
        tick();
        bus.en_fetch_pulse = 1'b0;
        bus.en_pc_pulse    = 1'b0;
        bus.pc_ctrl        = 2'b00;
        if (pc_en) check_eq("pc_update", 32'(bus.pc), 32'(m_pc));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check_eq("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"},   32'(bus.pc),        32'h00);
        check_eq({tag, "_ir"},   32'(bus.ir),        32'h00);
        check_eq({tag, "_req"},  32'(bus.imem_req),  32'd0);
        check_eq({tag, "_addr"}, 32'(bus.imem_addr), 32'h00);
        check_eq({tag, "_en1"},  32'(bus.en1),       32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy),      32'd0);
        check_eq({tag, "_err"},  32'(bus.fetch_err), 32'd0);
    endtask

    // Memory responder: acks after mem_delay request cycles without ack.
    initial begin
        int wait_cnt = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 8'h00;
        forever begin
            tick();
            if (force_ack) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 8'hA5;
            end else if (bus.imem_req && wait_cnt == mem_delay) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem[bus.imem_addr];
                wait_cnt       = 0;
            end else if (bus.imem_req) begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 8'h00;
                wait_cnt++;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 8'h00;
                wait_cnt       = 0;
            end
        end
    end

    // Scoreboard monitor on en1.
    initial begin
        bit prev_en1 = 1'b0;
        logic [8:0] exp;
        forever begin
            tick();
            if (rst_n && bus.en1) begin
                n_en1++;
                if (prev_en1) check_eq("en1_single", 32'(prev_en1), 32'd0);
                if (sb.size() == 0) begin
                    check_eq("en1_unexpected", 32'(bus.en1), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check_eq("sb_ir",  32'(bus.ir),        32'(exp[8:1]));
                    check_eq("sb_err", 32'(bus.fetch_err), 32'(exp[0]));
                end
            end
            prev_en1 = rst_n && bus.en1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h00] = 8'h9D;
        bus.en_fetch_pulse = 1'b0;
        bus.en_pc_pulse    = 1'b0;
        bus.pc_ctrl        = 2'b00;
        bus.pc_load_val    = 8'h00;

        // 1: reset values, zero-wait fetch
        tick(); tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        mem_delay = 0;
        drive_cycle(1, 0, 2'b00, 8'h00, 1, 0);
        check_eq("t1_req",   32'(bus.imem_req),  32'd1);
        check_eq("t1_addr",  32'(bus.imem_addr), 32'h00);
        check_eq("t1_busy",  32'(bus.busy),      32'd1);
        check_eq("t1_en1_c1", 32'(bus.en1),      32'd0);
        tick();
        check_eq("t1_en1_c2", 32'(bus.en1),    32'd1);
        check_eq("t1_ir",     32'(bus.ir),     32'h9D);
        check_eq("t1_opcode", 32'(bus.opcode), 32'h9);
        check_eq("t1_rd",     32'(bus.rd),     32'h3);
        check_eq("t1_rs",     32'(bus.rs),     32'h1);
        check_eq("t1_busy_c2", 32'(bus.busy),  32'd1);
        tick();
        check_eq("t1_en1_c3",  32'(bus.en1),  32'd0);
        check_eq("t1_busy_c3", 32'(bus.busy), 32'd0);

        // 2: ack delayed 3 cycles
        drive_cycle(0, 1, 2'b10, 8'h10, 0, 0);
        mem_delay = 3;
        drive_cycle(1, 0, 2'b00, 8'h00, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            check_eq("t2_req_hold",  32'(bus.imem_req),  32'd1);
            check_eq("t2_addr_hold", 32'(bus.imem_addr), 32'h10);
            check_eq("t2_en1_low",   32'(bus.en1),       32'd0);
            tick();
        end
        check_eq("t2_req_ackcyc", 32'(bus.imem_req), 32'd1);
        check_eq("t2_en1_ackcyc", 32'(bus.en1),      32'd0);
        tick();
        check_eq("t2_en1",    32'(bus.en1),      32'd1);
        check_eq("t2_req_lo", 32'(bus.imem_req), 32'd0);
        check_eq("t2_ir",     32'(bus.ir),       32'(mem[8'h10]));
        tick();
        check_eq("t2_en1_after", 32'(bus.en1), 32'd0);
        wait_idle();

        // 3: fetch with simultaneous increment, including wrap
        mem_delay = 0;
        drive_cycle(0, 1, 2'b10, 8'h05, 0, 0);
        drive_cycle(1, 1, 2'b01, 8'h00, 1, 0);
        check_eq("t3_addr", 32'(bus.imem_addr), 32'h05);
        check_eq("t3_pc",   32'(bus.pc),        32'h06);
        wait_idle();
        drive_cycle(0, 1, 2'b10, 8'hFF, 0, 0);
        drive_cycle(1, 1, 2'b01, 8'h00, 1, 0);
        check_eq("t3_addr_ff", 32'(bus.imem_addr), 32'hFF);
        check_eq("t3_pc_wrap", 32'(bus.pc),        32'h00);
        wait_idle();

        // 4: load, hold, reset-to-RESET_PC; second pulse in REQ ignored
        drive_cycle(0, 1, 2'b10, 8'h3C, 0, 0);
        check_eq("t4_pc_load", 32'(bus.pc), 32'h3C);
        drive_cycle(0, 1, 2'b00, 8'h77, 0, 0);
        check_eq("t4_pc_hold", 32'(bus.pc), 32'h3C);
        drive_cycle(0, 1, 2'b11, 8'h77, 0, 0);
        check_eq("t4_pc_rst", 32'(bus.pc), 32'h00);
        drive_cycle(0, 1, 2'b10, 8'h21, 0, 0);
        mem_delay = 2;
        n0 = n_en1;
        drive_cycle(1, 0, 2'b00, 8'h00, 1, 0);
        drive_cycle(1, 0, 2'b00, 8'h00, 0, 0);
        wait_idle();
        for (int i = 0; i < 6; i++) tick();
        check_eq("t4_one_en1", 32'(n_en1 - n0), 32'd1);
        check_eq("t4_req_idle", 32'(bus.imem_req), 32'd0);

        // 5: reset mid-REQ, late ack ignored
        mem_delay = 1000;
        n0 = n_en1;
        drive_cycle(1, 0, 2'b00, 8'h00, 0, 0);
        tick();
        check_eq("t5_in_req", 32'(bus.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 m_pc = 8'h00;
        check_reset_outputs("t5_async");
        tick();
        rst_n = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        force_ack = 1'b0;
        tick();
        check_reset_outputs("t5_post");
        check_eq("t5_no_en1", 32'(n_en1 - n0), 32'd0);

        // 6: memory never acks
        n0 = n_en1;
`ifdef IFU_TIMEOUT_EN
        drive_cycle(1, 0, 2'b00, 8'h00, 1, 1);
        for (int c = 1; c < 16; c++) tick();
        check_eq("t6_en1_c16", 32'(bus.en1),      32'd0);
        check_eq("t6_req_c16", 32'(bus.imem_req), 32'd1);
        tick();
        check_eq("t6_en1_c17", 32'(bus.en1),       32'd1);
        check_eq("t6_err_c17", 32'(bus.fetch_err), 32'd1);
        check_eq("t6_ir_c17",  32'(bus.ir),        32'h00);
        tick();
        check_eq("t6_err_clr", 32'(bus.fetch_err), 32'd0);
        check_eq("t6_one_en1", 32'(n_en1 - n0),    32'd1);
`else
        drive_cycle(1, 0, 2'b00, 8'h00, 0, 0);
        for (int c = 1; c < 100; c++) tick();
        check_eq("t6_req_c100",  32'(bus.imem_req),  32'd1);
        check_eq("t6_busy_c100", 32'(bus.busy),      32'd1);
        check_eq("t6_err_c100",  32'(bus.fetch_err), 32'd0);
        check_eq("t6_no_en1",    32'(n_en1 - n0),    32'd0);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc = 8'h00;
`endif
        tick(); tick();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Responder to the control FSM's fetch/PC handshake.
- Owns the program counter and updates it on PC pulses according to pc_ctrl.
- On a fetch pulse, performs one req/ack read from instruction memory, latches the instruction register and decoded fields, then returns the single-cycle en1 "fetch done" to the FSM.
- Sits between the control FSM and the instruction ROM/RAM.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 8, instruction width; fixed split [7:4] opcode, [3:2] rd, [1:0] rs.
- RESET_PC, 0, PC value after reset and after pc_ctrl=11.
- TIMEOUT, 16, cycles waited for imem_ack before abort (only with IFU_TIMEOUT_EN; must be >=2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en_fetch_pulse  in  1  one-cycle fetch request from the FSM
- en_pc_pulse  in  1  one-cycle PC update strobe
- pc_ctrl  in  2  00 hold, 01 increment, 10 load pc_load_val, 11 reset to RESET_PC
- pc_load_val  in  ADDR_W  branch/jump target for pc_ctrl=10
- imem_req  out  1  memory read request, registered
- imem_addr  out  ADDR_W  read address, stable while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  INSTR_W  instruction data, sampled when imem_ack=1
- pc  out  ADDR_W  current program counter
- ir  out  INSTR_W  latched instruction
- opcode  out  4  ir[7:4]
- rd  out  2  ir[3:2]
- rs  out  2  ir[1:0]
- en1  out  1  fetch-done pulse to the FSM, registered
- busy  out  1  high in REQ or DONE
- fetch_err  out  1  high for the same cycle as en1 when the fetch timed out

Behaviour:
- Reset (async, any state): pc=RESET_PC; ir=0; imem_req=0; imem_addr=0; en1=0; busy=0; fetch_err=0; state=IDLE. An in-flight request is dropped; a later imem_ack is ignored.
- PC update happens on any clock edge with en_pc_pulse=1, regardless of fetch state:
  - 00: hold.
  - 01: pc+1, modulo 2^ADDR_W, so all-ones wraps to 0.
  - 10: pc_load_val.
  - 11: RESET_PC.
- States: IDLE, REQ, DONE.
- IDLE:
  - en_fetch_pulse=1 -> REQ; imem_req<=1; imem_addr<=pc, using the pre-update pc even if en_pc_pulse is high in the same cycle.
  - imem_ack is ignored.
- REQ: imem_req stays 1 and imem_addr stays stable.
  - On an edge with imem_ack=1: ir<=imem_rdata, imem_req<=0, en1<=1 -> DONE.
  - Without ack: remain in REQ.
- DONE: en1=1 for exactly this one cycle, then -> IDLE with en1<=0.
- en_fetch_pulse in REQ or DONE is ignored; no queuing.
- Latency: pulse at cycle 0 with ack arriving in cycle k (k>=1) -> en1 high in cycle k+1. Zero-wait memory gives en1 in cycle 2.
- opcode, rd and rs are combinational slices of ir and change only when ir loads.
- en1 never stays high across consecutive cycles, so the FSM cannot skip a later IF state.

Optional Feature:
- Macro: IFU_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and is cleared on REQ entry.
  - If TIMEOUT cycles elapse in REQ with no ack: ir<=0, imem_req<=0, en1<=1, fetch_err<=1 -> DONE.
  - fetch_err clears with en1.
  - An ack arriving in the same cycle the limit is reached wins: normal load, fetch_err=0.
- Undefined: no counter; REQ waits indefinitely; fetch_err is tied to 0.

Test Plan:
1. Reset, then pulse en_fetch_pulse with ack in the same cycle as req and imem_rdata=8'h9D -> imem_addr=0; en1 high exactly cycle 2; ir=9D, opcode=9, rd=3, rs=1; busy falls after DONE.
2. Ack delayed 3 cycles -> imem_req and imem_addr held for 3 cycles; en1 a single pulse 1 cycle after ack.
3. en_fetch_pulse plus en_pc_pulse (pc_ctrl=01) with pc=8'h05 -> imem_addr=05, pc=06. Repeat at pc=FF -> pc wraps to 00.
4. pc_ctrl=10 with pc_load_val=8'h3C, then pc_ctrl=11 -> pc=3C, then RESET_PC. A second fetch pulse while in REQ is ignored and exactly one en1 is produced.
5. Assert rst_n=0 mid-REQ, then ack after release -> all outputs return to reset values; no en1; ir stays 0.
6. With IFU_TIMEOUT_EN and TIMEOUT=16, never ack -> en1 and fetch_err high together in cycle 17; ir=0. Without the macro -> still in REQ at cycle 100.
